// File: rtl/jk_ff_array_pkg.sv
// jk_pkg: shared types and per-bit next-state function for the jk_ff_array
// flip-flop bank.
//   jk_mode_t  : update mode selected on each edge (JK / D / T / SR)
//   jk_next_t  : {q_next, illegal} result of one bit's next-state evaluation
//   jk_next()  : pure next-state function for a single channel
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } jk_mode_t;

  typedef struct packed {
    logic q_next;
    logic illegal;
  } jk_next_t;

  // Next state of one channel assuming the enable path is taken.
  // 'illegal' is only raised for SR with both S and R high; that case holds q.
  function automatic jk_next_t jk_next(jk_mode_t mode, logic j, logic k, logic q);
    jk_next_t r;
    r.q_next  = q;
    r.illegal = 1'b0;
    unique case (mode)
      MODE_JK: begin
        unique case ({j, k})
          2'b00: r.q_next = q;
          2'b01: r.q_next = 1'b0;
          2'b10: r.q_next = 1'b1;
          2'b11: r.q_next = ~q;
          default: r.q_next = q;
        endcase
      end
      MODE_D: r.q_next = j;
      MODE_T: r.q_next = q ^ j;
      MODE_SR: begin
        unique case ({j, k})
          2'b10: r.q_next = 1'b1;
          2'b01: r.q_next = 1'b0;
          2'b11: begin
            r.q_next  = q;
            r.illegal = 1'b1;
          end
          default: r.q_next = q;
        endcase
      end
      default: r.q_next = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_ff_array_if.sv
// jk_ff_array_if: control/status bus of the jk_ff_array register bank.
//   master : drives en, load, load_val, mode, j, k, stat_clr; observes outputs
//   slave  : the bank itself; drives q, q_n, chg, sr_err, tog_cnt
interface jk_ff_array_if
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  jk_mode_t         mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             stat_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] chg;
  logic             sr_err;
  logic [CNT_W-1:0] tog_cnt;

  modport master (
    output en, load, load_val, mode, j, k, stat_clr,
    input  q, q_n, chg, sr_err, tog_cnt
  );

  modport slave (
    input  en, load, load_val, mode, j, k, stat_clr,
    output q, q_n, chg, sr_err, tog_cnt
  );

endinterface

// File: rtl/jk_ff_array_bit_next.sv
// jk_bit_next: combinational next-state of one flip-flop channel.
//   mode    : update mode for this edge
//   j, k    : channel inputs (J/D/T/S and K/R)
//   q       : current state
//   q_next  : state if the enable path is taken
//   illegal : SR mode with S=R=1 on this channel
module jk_bit_next
  import jk_pkg::*;
(
  input  jk_mode_t mode,
  input  logic     j,
  input  logic     k,
  input  logic     q,
  output logic     q_next,
  output logic     illegal
);

  jk_next_t nx;

  assign nx      = jk_next(mode, j, k, q);
  assign q_next  = nx.q_next;
  assign illegal = nx.illegal;

endmodule

// File: rtl/jk_ff_array.sv
// jk_ff_array: WIDTH-channel multi-mode flip-flop bank (JK / D / T / SR) with
// clock enable, parallel load, sticky SR-illegal flag, per-bit change strobe
// and a saturating activity counter.
//   clk : clock, all state updates on posedge
//   rst : synchronous active-high reset (q=RST_VAL, status cleared)
//   bus : slave side of jk_ff_array_if
//         in : en, load, load_val, mode, j, k, stat_clr
//         out: q, q_n, chg, sr_err, tog_cnt
// Edge priority: rst > load > en > hold.
module jk_ff_array
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  jk_ff_array_if.slave  bus
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] chg_r;
  logic             sr_err_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] q_upd;    // per-bit next state on the enable path
  logic [WIDTH-1:0] ill_vec;  // per-bit SR-illegal
  logic [WIDTH-1:0] q_nx;     // next state after load/en/hold selection
  logic             upd_path; // enable path actually taken this edge
  logic             ill_evt;
  logic             cnt_evt;
  logic             cnt_sat;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_bit_next u_bit (
      .mode    (bus.mode),
      .j       (bus.j[g]),
      .k       (bus.k[g]),
      .q       (q_r[g]),
      .q_next  (q_upd[g]),
      .illegal (ill_vec[g])
    );
  end

  always_comb begin
    upd_path = bus.en & ~bus.load;
    q_nx     = q_r;
    if (bus.load)     q_nx = bus.load_val;
    else if (bus.en)  q_nx = q_upd;
    // Load shadows the enable path, so neither the flag nor the counter
    // may see its illegal/change terms.
    ill_evt  = upd_path & (|ill_vec);
    cnt_evt  = upd_path & (|(q_upd ^ q_r));
    cnt_sat  = &cnt_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r      <= RST_VAL;
      chg_r    <= '0;
      sr_err_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      q_r      <= q_nx;
      chg_r    <= q_nx ^ q_r;
      // Clear first, then set: a new illegal event on the clearing edge wins.
      sr_err_r <= (sr_err_r & ~bus.stat_clr) | ill_evt;
      if (bus.stat_clr)
        cnt_r <= CNT_W'(cnt_evt);
      else if (cnt_evt && !cnt_sat)
        cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bus.q       = q_r;
  assign bus.q_n     = ~q_r;
  assign bus.chg     = chg_r;
  assign bus.sr_err  = sr_err_r;
  assign bus.tog_cnt = cnt_r;

endmodule

// File: tb/tb_jk_ff_array.sv
// Bench for jk_ff_array. Two instances share all stimulus: dut_a with CNT_W=8
// and dut_b with CNT_W=2 (to reach counter saturation quickly). A reference
// model pushes expected outputs to a scoreboard queue before every edge; each
// test task pops and compares after the edge, plus spot checks of hand-derived
// values.
module tb_jk_ff_array;
  import jk_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en, load, clr;
  logic [7:0] lv, jv, kv;
  jk_mode_t   mode;

  jk_ff_array_if #(.WIDTH(8), .CNT_W(8)) ifa ();
  jk_ff_array_if #(.WIDTH(8), .CNT_W(2)) ifb ();

  assign ifa.en = en;   assign ifa.load = load; assign ifa.load_val = lv;
  assign ifa.mode = mode; assign ifa.j = jv;  assign ifa.k = kv;
  assign ifa.stat_clr = clr;
  assign ifb.en = en;   assign ifb.load = load; assign ifb.load_val = lv;
  assign ifb.mode = mode; assign ifb.j = jv;  assign ifb.k = kv;
  assign ifb.stat_clr = clr;

  jk_ff_array #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  jk_ff_array #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct packed {
    logic rst, load, en, clr;
    logic [1:0] mode;
    logic [7:0] lv, j, k;
  } stim_t;

  typedef struct {
    logic [7:0] q, chg;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t sbq[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] m_q, m_chg, m_cnt;
  logic       m_err;
  logic [1:0] m_cnt2;

  task automatic apply(input stim_t s);
    rst = s.rst; load = s.load; en = s.en; clr = s.clr;
    mode = jk_mode_t'(s.mode); lv = s.lv; jv = s.j; kv = s.k;
  endtask

  // Model the coming edge, queue the expectation, then advance past the edge.
  task automatic tick();
    exp_t e;
    logic [7:0] f, nq;
    logic ill, upd;
    if (rst) begin
      m_q = 8'h00; m_chg = 8'h00; m_err = 1'b0; m_cnt = 8'h00; m_cnt2 = 2'd0;
    end else begin
      ill = 1'b0;
      for (int i = 0; i < 8; i++) begin
        case (mode)
          MODE_JK: f[i] = jv[i] ? (kv[i] ? ~m_q[i] : 1'b1) : (kv[i] ? 1'b0 : m_q[i]);
          MODE_D:  f[i] = jv[i];
          MODE_T:  f[i] = m_q[i] ^ jv[i];
          default: begin
            if (jv[i] && kv[i]) begin f[i] = m_q[i]; ill = 1'b1; end
            else if (jv[i]) f[i] = 1'b1;
            else if (kv[i]) f[i] = 1'b0;
            else f[i] = m_q[i];
          end
        endcase
      end
      nq  = load ? lv : (en ? f : m_q);
      upd = en && !load && (f != m_q);
      ill = ill && en && !load;
      m_chg = nq ^ m_q;
      m_q   = nq;
      m_err = clr ? ill : (m_err | ill);
      if (clr) begin
        m_cnt = {7'd0, upd}; m_cnt2 = {1'b0, upd};
      end else if (upd) begin
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
    end
    e.q = m_q; e.chg = m_chg; e.err = m_err; e.cnt = m_cnt; e.cnt2 = m_cnt2;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    stim_t s;
    s = '{rst:1'b1, load:1'b1, en:1'b1, clr:1'b0, mode:2'b10, lv:8'hFF, j:8'hFF, k:8'h00};
    for (int i = 0; i < 2; i++) begin
      apply(s); tick(); e = sbq.pop_front(); total_cnt++;
      if ({ifa.q, ifa.q_n, ifa.chg, ifa.sr_err, ifa.tog_cnt, ifb.q, ifb.tog_cnt} !==
          {e.q, ~e.q, e.chg, e.err, e.cnt, e.q, e.cnt2})
        $display("FAIL reset[%0d]: got q=%h chg=%h err=%b cnt=%h, want q=%h chg=%h err=%b cnt=%h",
                 i, ifa.q, ifa.chg, ifa.sr_err, ifa.tog_cnt, e.q, e.chg, e.err, e.cnt);
      else pass_cnt++;
    end
    total_cnt++;
    if ({ifa.q, ifa.chg, ifa.sr_err, ifa.tog_cnt, ifb.tog_cnt} !== 27'h0)
      $display("FAIL reset_state: got q=%h chg=%h err=%b cnt=%h cnt2=%h, want all 0",
               ifa.q, ifa.chg, ifa.sr_err, ifa.tog_cnt, ifb.tog_cnt);
    else pass_cnt++;
  endtask

  // Shared pattern of the directed tasks: table of stimulus plus spec-derived q/chg/cnt.
  task automatic test_jk();
    exp_t e;
    stim_t st [3];
    logic [7:0] xq [3], xc [3], xn [3];
    st[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'hF0, 8'h0F};
    st[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'hFF, 8'hFF};
    st[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'hFF, 8'hFF};
    xq = '{8'hF0, 8'h0F, 8'h0F}; xc = '{8'hF0, 8'hFF, 8'h00}; xn = '{8'd1, 8'd2, 8'd2};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]); tick(); e = sbq.pop_front(); total_cnt++;
      if ({ifa.q, ifa.q_n, ifa.chg, ifa.sr_err, ifa.tog_cnt, ifb.q, ifb.tog_cnt} !==
          {e.q, ~e.q, e.chg, e.err, e.cnt, e.q, e.cnt2})
        $display("FAIL jk_sb[%0d]: got q=%h chg=%h err=%b cnt=%h, want q=%h chg=%h err=%b cnt=%h",
                 i, ifa.q, ifa.chg, ifa.sr_err, ifa.tog_cnt, e.q, e.chg, e.err, e.cnt);
      else pass_cnt++;
      total_cnt++;
      if ({ifa.q, ifa.chg, ifa.tog_cnt} !== {xq[i], xc[i], xn[i]})
        $display("FAIL jk_spot[%0d]: got q=%h chg=%h cnt=%h, want q=%h chg=%h cnt=%h",
                 i, ifa.q, ifa.chg, ifa.tog_cnt, xq[i], xc[i], xn[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_modes();
    exp_t e;
    stim_t st [3];
    logic [7:0] xq [3], xc [3], xn [3];
    logic       xe [3];
    st[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 8'h00, 8'hA5, 8'h00};
    st[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 8'hFF, 8'h00};
    st[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 8'h00, 8'h01, 8'h01};
    xq = '{8'hA5, 8'h5A, 8'h5A}; xc = '{8'hAA, 8'hFF, 8'h00};
    xn = '{8'd3, 8'd4, 8'd4};    xe = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]); tick(); e = sbq.pop_front(); total_cnt++;
      if ({ifa.q, ifa.q_n, ifa.chg, ifa.sr_err, ifa.tog_cnt, ifb.q, ifb.tog_cnt} !==
          {e.q, ~e.q, e.chg, e.err, e.cnt, e.q, e.cnt2})
        $display("FAIL mode_sb[%0d]: got q=%h chg=%h err=%b cnt=%h, want q=%h chg=%h err=%b cnt=%h",
                 i, ifa.q, ifa.chg, ifa.sr_err, ifa.tog_cnt, e.q, e.chg, e.err, e.cnt);
      else pass_cnt++;
      total_cnt++;
      if ({ifa.q, ifa.chg, ifa.sr_err, ifa.tog_cnt} !== {xq[i], xc[i], xe[i], xn[i]})
        $display("FAIL mode_spot[%0d]: got q=%h chg=%h err=%b cnt=%h, want q=%h chg=%h err=%b cnt=%h",
                 i, ifa.q, ifa.chg, ifa.sr_err, ifa.tog_cnt, xq[i], xc[i], xe[i], xn[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_load();
    exp_t e;
    apply('{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 8'h3C, 8'hFF, 8'h00});
    tick(); e = sbq.pop_front(); total_cnt++;
    if ({ifa.q, ifa.q_n, ifa.chg, ifa.sr_err, ifa.tog_cnt, ifb.q, ifb.tog_cnt} !==
        {e.q, ~e.q, e.chg, e.err, e.cnt, e.q, e.cnt2})
      $display("FAIL load_sb: got q=%h chg=%h err=%b cnt=%h, want q=%h chg=%h err=%b cnt=%h",
               ifa.q, ifa.chg, ifa.sr_err, ifa.tog_cnt, e.q, e.chg, e.err, e.cnt);
    else pass_cnt++;
    total_cnt++;
    if ({ifa.q, ifa.chg, ifa.tog_cnt} !== {8'h3C, 8'h66, 8'd4})
      $display("FAIL load_spot: got q=%h chg=%h cnt=%h, want q=3c chg=66 cnt=04",
               ifa.q, ifa.chg, ifa.tog_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    exp_t e;
    stim_t st [8];
    logic [1:0] xn [8];
    st[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 8'h00, 8'hFF, 8'h00};
    for (int i = 1; i < 6; i++) st[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 8'hFF, 8'h00};
    st[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 8'h00, 8'hFF, 8'h00};
    st[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 8'h00, 8'hFF, 8'h00};
    xn = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0};
    for (int i = 0; i < 8; i++) begin
      apply(st[i]); tick(); e = sbq.pop_front(); total_cnt++;
      if ({ifa.q, ifa.q_n, ifa.chg, ifa.sr_err, ifa.tog_cnt, ifb.q, ifb.tog_cnt} !==
          {e.q, ~e.q, e.chg, e.err, e.cnt, e.q, e.cnt2})
        $display("FAIL sat_sb[%0d]: got q=%h err=%b cnt=%h cnt2=%h, want q=%h err=%b cnt=%h cnt2=%h",
                 i, ifa.q, ifa.sr_err, ifa.tog_cnt, ifb.tog_cnt, e.q, e.err, e.cnt, e.cnt2);
      else pass_cnt++;
      total_cnt++;
      if (ifb.tog_cnt !== xn[i])
        $display("FAIL sat_spot[%0d]: got cnt2=%h, want %h", i, ifb.tog_cnt, xn[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (ifa.sr_err !== 1'b0)
      $display("FAIL clr_alone_err: got sr_err=%b, want 0", ifa.sr_err);
    else pass_cnt++;
  endtask

  task automatic test_clr_rst();
    exp_t e;
    stim_t st [6];
    logic [7:0] xq [6];
    logic       xe [6];
    st[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 8'h00, 8'h80, 8'h80};
    st[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 8'h00, 8'h80, 8'h80};
    st[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 8'h01, 8'h00};
    st[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 8'hAA, 8'h01, 8'h00};
    st[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 8'h01, 8'h00};
    st[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 8'h03, 8'h00};
    xq = '{8'h3C, 8'h3C, 8'h3D, 8'h00, 8'h01, 8'h02};
    xe = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(st[i]); tick(); e = sbq.pop_front(); total_cnt++;
      if ({ifa.q, ifa.q_n, ifa.chg, ifa.sr_err, ifa.tog_cnt, ifb.q, ifb.tog_cnt} !==
          {e.q, ~e.q, e.chg, e.err, e.cnt, e.q, e.cnt2})
        $display("FAIL clrrst_sb[%0d]: got q=%h chg=%h err=%b cnt=%h, want q=%h chg=%h err=%b cnt=%h",
                 i, ifa.q, ifa.chg, ifa.sr_err, ifa.tog_cnt, e.q, e.chg, e.err, e.cnt);
      else pass_cnt++;
      total_cnt++;
      if ({ifa.q, ifa.sr_err} !== {xq[i], xe[i]})
        $display("FAIL clrrst_spot[%0d]: got q=%h err=%b, want q=%h err=%b",
                 i, ifa.q, ifa.sr_err, xq[i], xe[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({ifa.chg, ifa.tog_cnt} !== {8'h03, 8'd2})
      $display("FAIL resume_after_rst: got chg=%h cnt=%h, want chg=03 cnt=02", ifa.chg, ifa.tog_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    stim_t s;
    for (int i = 0; i < 80; i++) begin
      s.rst  = ($urandom_range(0, 19) == 0);
      s.load = ($urandom_range(0, 7) == 0);
      s.en   = ($urandom_range(0, 3) != 0);
      s.clr  = ($urandom_range(0, 9) == 0);
      s.mode = 2'($urandom_range(0, 3));
      s.lv   = 8'($urandom);
      s.j    = 8'($urandom);
      s.k    = 8'($urandom);
      apply(s); tick(); e = sbq.pop_front(); total_cnt++;
      if ({ifa.q, ifa.q_n, ifa.chg, ifa.sr_err, ifa.tog_cnt, ifb.q, ifb.tog_cnt} !==
          {e.q, ~e.q, e.chg, e.err, e.cnt, e.q, e.cnt2})
        $display("FAIL b2b[%0d]: got q=%h qn=%h chg=%h err=%b cnt=%h cnt2=%h, want q=%h chg=%h err=%b cnt=%h cnt2=%h",
                 i, ifa.q, ifa.q_n, ifa.chg, ifa.sr_err, ifa.tog_cnt, ifb.tog_cnt,
                 e.q, e.chg, e.err, e.cnt, e.cnt2);
      else pass_cnt++;
    end
  endtask

  initial begin
    apply('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00});
    test_reset();
    test_jk();
    test_modes();
    test_load();
    test_saturate();
    test_clr_rst();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
